// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: load extraction opcodes and
// writeback source selects.
package wb_pkg;

    localparam int XLEN  = 32;
    localparam int IDX_W = 5;

    typedef enum logic [3:0] {
        DMOP_W   = 4'd0,
        DMOP_LB  = 4'd1,
        DMOP_LBU = 4'd2,
        DMOP_LH  = 4'd3,
        DMOP_LHU = 4'd4
    } dm_op_e;

    typedef enum logic [1:0] {
        WSEL_AO  = 2'd0,
        WSEL_DR  = 2'd1,
        WSEL_PC8 = 2'd2,
        WSEL_HL  = 2'd3
    } wsel_e;

endpackage

// File: rtl/wb_grf_if.sv
// W-stage pipeline bundle, D-stage read ports and writeback trace, grouped so
// the pipeline (master) and the writeback stage (slave) share one port.
interface wb_grf_if;
    import wb_pkg::*;

    logic              RegWrite_W;
    logic [3:0]        DM_Op_W;
    logic [1:0]        Wlevel_Sel_W;
    logic [XLEN-1:0]   Instr_W;
    logic [XLEN-1:0]   PC_W;
    logic [XLEN-1:0]   AO_W;
    logic [XLEN-1:0]   DR_W;
    logic [IDX_W-1:0]  A3_W;
    logic [XLEN-1:0]   HL_W;
    logic [IDX_W-1:0]  A1_D;
    logic [IDX_W-1:0]  A2_D;

    logic [XLEN-1:0]   RD1_D;
    logic [XLEN-1:0]   RD2_D;
    logic [XLEN-1:0]   WD_W;
    logic              wb_we;
    logic [XLEN-1:0]   wb_pc;
    logic [XLEN-1:0]   wb_data;
    logic [IDX_W-1:0]  wb_addr;
    logic [XLEN-1:0]   retire_cnt;

    modport master (
        output RegWrite_W, DM_Op_W, Wlevel_Sel_W, Instr_W, PC_W, AO_W, DR_W,
               A3_W, HL_W, A1_D, A2_D,
        input  RD1_D, RD2_D, WD_W, wb_we, wb_pc, wb_data, wb_addr, retire_cnt
    );

    modport slave (
        input  RegWrite_W, DM_Op_W, Wlevel_Sel_W, Instr_W, PC_W, AO_W, DR_W,
               A3_W, HL_W, A1_D, A2_D,
        output RD1_D, RD2_D, WD_W, wb_we, wb_pc, wb_data, wb_addr, retire_cnt
    );

endinterface

// File: rtl/wb_grf_load_ext.sv
// Load data extraction: picks the byte/half lane from the raw memory word
// and sign- or zero-extends it; unknown opcodes pass the word through.
module load_ext
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] DR,
    input  logic [1:0]      addr_lo,
    input  logic [3:0]      DM_Op,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        byte_sel = DR[7:0];
        case (addr_lo)
            2'd0: byte_sel = DR[7:0];
            2'd1: byte_sel = DR[15:8];
            2'd2: byte_sel = DR[23:16];
            2'd3: byte_sel = DR[31:24];
            default: byte_sel = DR[7:0];
        endcase
        half_sel = addr_lo[1] ? DR[31:16] : DR[15:0];

        ext = DR;
        case (DM_Op)
            DMOP_LB:  ext = {{24{byte_sel[7]}}, byte_sel};
            DMOP_LBU: ext = {24'h0, byte_sel};
            DMOP_LH:  ext = {{16{half_sel[15]}}, half_sel};
            DMOP_LHU: ext = {16'h0, half_sel};
            default:  ext = DR;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage: selects the writeback value, commits it to the register
// file with same-cycle read bypass, and counts retired instructions.
module wb_grf
    import wb_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int PC_OFFSET = 8
) (
    input  logic     clk,
    input  logic     reset,
    wb_grf_if.slave  bus
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] retire_q, retire_d;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wd;
    logic            we;

    load_ext u_load_ext (
        .DR      (bus.DR_W),
        .addr_lo (bus.AO_W[1:0]),
        .DM_Op   (bus.DM_Op_W),
        .ext     (load_data)
    );

    always_comb begin
        wd = bus.AO_W;
        case (bus.Wlevel_Sel_W)
            WSEL_AO:  wd = bus.AO_W;
            WSEL_DR:  wd = load_data;
            WSEL_PC8: wd = bus.PC_W + XLEN'(PC_OFFSET);
            WSEL_HL:  wd = bus.HL_W;
            default:  wd = bus.AO_W;
        endcase
    end

    // Gating with reset keeps the bypass and trace silent while reset is held.
    assign we = bus.RegWrite_W && (bus.A3_W != '0) && reset;

    always_comb begin
        bus.RD1_D = '0;
        if (bus.A1_D != '0)
            bus.RD1_D = (we && bus.A3_W == bus.A1_D) ? wd : regs_q[bus.A1_D];
        bus.RD2_D = '0;
        if (bus.A2_D != '0)
            bus.RD2_D = (we && bus.A3_W == bus.A2_D) ? wd : regs_q[bus.A2_D];
    end

    assign retire_d = retire_q + ((bus.Instr_W != '0) ? XLEN'(1) : XLEN'(0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the register array is reset explicitly, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            retire_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates ordered against the same edge.
            if (we) regs_q[bus.A3_W] <= wd;
            retire_q <= retire_d;
        end
    end

    assign bus.WD_W       = wd;
    assign bus.wb_we      = we;
    assign bus.wb_pc      = bus.PC_W;
    assign bus.wb_addr    = bus.A3_W;
    assign bus.wb_data    = wd;
    assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_grf.sv
// Directed self-checking bench for wb_grf: reset, load extraction, bypass,
// register 0, link values, retire counting and counter wrap.
module tb_wb_grf;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wb_grf_if bus ();

    wb_grf #(.NREG(32), .PC_OFFSET(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        bus.RegWrite_W   = 1'b0;
        bus.DM_Op_W      = 4'd0;
        bus.Wlevel_Sel_W = 2'd0;
        bus.Instr_W      = 32'h0;
        bus.PC_W         = 32'h0;
        bus.AO_W         = 32'h0;
        bus.DR_W         = 32'h0;
        bus.A3_W         = 5'd0;
        bus.HL_W         = 32'h0;
        bus.A1_D         = 5'd0;
        bus.A2_D         = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        bus.RegWrite_W = 1'b1;
        bus.A3_W       = 5'd3;
        bus.AO_W       = 32'hAAAA_5555;
        bus.A1_D       = 5'd3;
        #1;
        checks++;
        if (bus.wb_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_wb_we got %0b want 0", bus.wb_we);
        end
        checks++;
        if (bus.RD1_D !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd1_nobypass got %h want 0", bus.RD1_D);
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            bus.A1_D = 5'(i);
            bus.A2_D = 5'(31 - i);
            #1;
            checks++;
            if (bus.RD1_D !== 32'h0 || bus.RD2_D !== 32'h0) begin
                errors++;
                $display("FAIL reset_read[%0d] got %h/%h want 0/0", i, bus.RD1_D, bus.RD2_D);
            end
        end
        checks++;
        if (bus.retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_retire got %h want 0", bus.retire_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_retire();
        logic [9:0] pattern;
        pattern = 10'b10_1101_0110;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle();
            bus.Instr_W = pattern[i] ? 32'h2000_0000 + 32'(i) : 32'h0;
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.retire_cnt !== 32'd6) begin
            errors++;
            $display("FAIL retire_count got %0d want 6", bus.retire_cnt);
        end
    endtask

    task automatic test_load_ext();
        logic [3:0]  ops   [7];
        logic [31:0] addrs [7];
        logic [31:0] exps  [7];
        ops   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd9, 4'd3};
        addrs = '{32'h2, 32'h2, 32'h0, 32'h0, 32'h1, 32'h3, 32'h2};
        exps  = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_F2F3, 32'h0000_F2F3,
                  32'h8081_F2F3, 32'h8081_F2F3, 32'hFFFF_8081};
        @(negedge clk);
        idle();
        bus.DR_W         = 32'h8081_F2F3;
        bus.Wlevel_Sel_W = 2'd1;
        bus.A3_W         = 5'd5;
        for (int i = 0; i < 7; i++) begin
            bus.DM_Op_W = ops[i];
            bus.AO_W    = addrs[i];
            #1;
            checks++;
            if (bus.WD_W !== exps[i]) begin
                errors++;
                $display("FAIL load_ext[%0d] op=%0d got %h want %h", i, ops[i], bus.WD_W, exps[i]);
            end
        end
        bus.Wlevel_Sel_W = 2'd3;
        bus.HL_W         = 32'h0BAD_F00D;
        #1;
        checks++;
        if (bus.WD_W !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL wsel_hl got %h want 0badf00d", bus.WD_W);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        bus.RegWrite_W = 1'b1;
        bus.A3_W       = 5'd7;
        bus.AO_W       = 32'h1234_5678;
        bus.PC_W       = 32'h0000_0400;
        bus.A1_D       = 5'd7;
        bus.A2_D       = 5'd7;
        #1;
        checks++;
        if (bus.RD1_D !== 32'h1234_5678 || bus.RD2_D !== 32'h1234_5678) begin
            errors++;
            $display("FAIL bypass_same_cycle got %h/%h want 12345678", bus.RD1_D, bus.RD2_D);
        end
        checks++;
        if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd7 || bus.wb_data !== 32'h1234_5678
            || bus.wb_pc !== 32'h0000_0400) begin
            errors++;
            $display("FAIL trace got we=%0b a=%0d d=%h pc=%h want 1/7/12345678/00000400",
                     bus.wb_we, bus.wb_addr, bus.wb_data, bus.wb_pc);
        end
        @(negedge clk);
        bus.RegWrite_W = 1'b0;
        bus.AO_W       = 32'h0;
        #1;
        checks++;
        if (bus.RD1_D !== 32'h1234_5678 || bus.RD2_D !== 32'h1234_5678) begin
            errors++;
            $display("FAIL stored_read got %h/%h want 12345678", bus.RD1_D, bus.RD2_D);
        end
        bus.RegWrite_W = 1'b1;
        bus.A3_W       = 5'd8;
        bus.AO_W       = 32'h0000_0BEE;
        bus.A2_D       = 5'd8;
        #1;
        checks++;
        if (bus.RD1_D !== 32'h1234_5678 || bus.RD2_D !== 32'h0000_0BEE) begin
            errors++;
            $display("FAIL bypass_one_port got %h/%h want 12345678/00000bee", bus.RD1_D, bus.RD2_D);
        end
    endtask

    task automatic test_r0();
        @(negedge clk);
        idle();
        bus.RegWrite_W = 1'b1;
        bus.A3_W       = 5'd0;
        bus.AO_W       = 32'hDEAD_BEEF;
        bus.A1_D       = 5'd0;
        #1;
        checks++;
        if (bus.RD1_D !== 32'h0 || bus.wb_we !== 1'b0) begin
            errors++;
            $display("FAIL r0_write got rd=%h we=%0b want 0/0", bus.RD1_D, bus.wb_we);
        end
        @(negedge clk);
        idle();
        bus.A2_D = 5'd0;
        #1;
        checks++;
        if (bus.RD2_D !== 32'h0) begin
            errors++;
            $display("FAIL r0_after got %h want 0", bus.RD2_D);
        end
    endtask

    task automatic test_link();
        @(negedge clk);
        idle();
        bus.RegWrite_W   = 1'b1;
        bus.Wlevel_Sel_W = 2'd2;
        bus.A3_W         = 5'd31;
        bus.PC_W         = 32'h0000_3000;
        #1;
        checks++;
        if (bus.WD_W !== 32'h0000_3008) begin
            errors++;
            $display("FAIL link got %h want 00003008", bus.WD_W);
        end
        @(negedge clk);
        bus.PC_W = 32'hFFFF_FFFC;
        #1;
        checks++;
        if (bus.WD_W !== 32'h0000_0004) begin
            errors++;
            $display("FAIL link_wrap got %h want 00000004", bus.WD_W);
        end
        @(negedge clk);
        idle();
        bus.A1_D = 5'd31;
        #1;
        checks++;
        if (bus.RD1_D !== 32'h0000_0004) begin
            errors++;
            $display("FAIL link_stored got %h want 00000004", bus.RD1_D);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        bus.RegWrite_W = 1'b1;
        bus.A3_W       = 5'd9;
        bus.AO_W       = 32'h0909_0909;
        bus.Instr_W    = 32'h1;
        @(negedge clk);
        bus.RegWrite_W = 1'b1;
        bus.A3_W       = 5'd10;
        bus.AO_W       = 32'h1010_1010;
        bus.A1_D       = 5'd9;
        #1;
        checks++;
        if (bus.RD1_D !== 32'h0909_0909) begin
            errors++;
            $display("FAIL pre_reset_read got %h want 09090909", bus.RD1_D);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.RD1_D !== 32'h0 || bus.retire_cnt !== 32'h0 || bus.wb_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got rd=%h cnt=%h we=%0b want 0/0/0",
                     bus.RD1_D, bus.retire_cnt, bus.wb_we);
        end
        @(negedge clk);
        reset = 1'b1;
        idle();
        bus.A1_D = 5'd10;
        bus.A2_D = 5'd9;
        #1;
        checks++;
        if (bus.RD1_D !== 32'h0 || bus.RD2_D !== 32'h0 || bus.retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL post_reset got %h/%h cnt=%h want 0/0/0", bus.RD1_D, bus.RD2_D, bus.retire_cnt);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        idle();
        force dut.retire_q = 32'hFFFF_FFFE;
        #1;
        release dut.retire_q;
        bus.Instr_W = 32'h0000_0020;
        @(negedge clk);
        checks++;
        if (bus.retire_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_max got %h want ffffffff", bus.retire_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.retire_cnt !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero got %h want 0", bus.retire_cnt);
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle();
        #12;
        test_reset();
        test_retire();
        test_load_ext();
        test_bypass();
        test_r0();
        test_link();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_grf.md
# wb_grf

Writeback stage and general register file for the five-stage MIPS pipeline. The block consumes the W-stage pipeline register bundle and extracts and sign/zero-extends load data. It selects the writeback value, commits it to a 32×32 register file, and serves the two D-stage read ports with same-cycle write bypass. It also keeps a retired-instruction counter and drives a per-cycle writeback trace for the test harness.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers; index width is log2(NREG)=5.
- `PC_OFFSET`, 8: link value offset added to `PC_W` for link writes.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `RegWrite_W`  in  1  write enable from W-stage register.
- `DM_Op_W`  in  4  load extraction opcode.
- `Wlevel_Sel_W`  in  2  writeback source select.
- `Instr_W`  in  32  instruction word; 0 marks a bubble.
- `PC_W`  in  32  instruction PC.
- `AO_W`  in  32  ALU result / memory address.
- `DR_W`  in  32  raw data-memory word.
- `A3_W`  in  5  destination register.
- `HL_W`  in  32  HI/LO read value.
- `A1_D`, `A2_D`  in  5 each  D-stage read addresses.
- `RD1_D`, `RD2_D`  out  32 each  D-stage read data, bypassed.
- `WD_W`  out  32  selected writeback value; forwarding source for earlier stages.
- `wb_we`  out  1  trace: a register is written this cycle.
- `wb_pc`, `wb_data`  out  32 each; `wb_addr`  out  5: trace of the write.
- `retire_cnt`  out  32  count of retired non-bubble instructions.

## Operation
- Load extraction. The byte lane is `AO_W[1:0]`; the half lane is `AO_W[1]`.
  - `DM_Op_W` 0: word pass-through.
  - 1: lb, sign-extended.
  - 2: lbu, zero-extended.
  - 3: lh, sign-extended.
  - 4: lhu, zero-extended.
  - 5–15: word pass-through.
- Source select by `Wlevel_Sel_W`:
  - 0: `AO_W`.
  - 1: extracted load data.
  - 2: `PC_W + PC_OFFSET`, 32-bit, wraps modulo 2^32.
  - 3: `HL_W`.
- Write condition: `we = RegWrite_W && A3_W != 0`. Register 0 is never written and always reads 0.
- Read with bypass:
  - `RDn_D = 0` if `An_D == 0`.
  - Otherwise, if `we && A3_W == An_D`, `RDn_D = WD_W`.
  - Otherwise, `RDn_D` is the stored register value.
- Trace outputs:
  - `wb_we = we`; `wb_pc = PC_W`; `wb_addr = A3_W`; `wb_data = WD_W`. All are combinational.
  - When `we` = 0, `wb_addr` and `wb_data` are don't-care but stable.
- Retire counter: increments by 1 for each cycle with `Instr_W != 0`, regardless of `RegWrite_W`. It wraps from 0xFFFFFFFF to 0.

## Timing
- Register write takes effect on the rising edge of `clk`. A read in the next cycle returns the new value from storage. A read in the same cycle returns it via the bypass, so there is zero-cycle write-to-read latency.
- `WD_W`, `RDn_D` and the trace outputs are purely combinational from inputs and storage; no output register.
- `reset` low asynchronously clears:
  - all 32 registers to 0;
  - `retire_cnt` to 0.
- While `reset` is low:
  - no write occurs;
  - `RDn_D` reads 0;
  - `wb_we` is forced to 0.
- Release is synchronous to `clk`: the first rising edge with `reset` high may write.
- Reset asserted mid-operation discards any write on that edge. No partial state survives.
- Simultaneous events:
  - A write to register k with both read ports addressing k returns `WD_W` on both.
  - A write to register 0 with a read of register 0 returns 0.

## Structure
- Shared package `wb_pkg`:
  - `DM_Op` encodings: `DMOP_W`, `DMOP_LB`, `DMOP_LBU`, `DMOP_LH`, `DMOP_LHU`.
  - `Wlevel_Sel` encodings: `WSEL_AO`, `WSEL_DR`, `WSEL_PC8`, `WSEL_HL`.
- One combinational sub-module, `load_ext`, with inputs (`DR`, `addr_lo[1:0]`, `DM_Op`) and output `ext[31:0]`.
- The register array, bypass logic, select mux and counter live in `wb_grf`.

## Test plan
- Reset, then read all addresses → `RDn_D` = 0 for all 32. Pulse `reset` low mid-cycle after writes → all cleared immediately; `retire_cnt` = 0.
- `DR_W`=0x8081_F2F3, `Wlevel_Sel_W`=1, `A3_W`=5:
  - `AO_W[1:0]`=2, lb → `WD_W`=0xFFFF_FF81.
  - lbu → 0x0000_0081.
  - `AO_W[1]`=0, lh → 0xFFFF_F2F3.
  - lhu → 0x0000_F2F3.
- `RegWrite_W`=1, `A3_W`=7, `AO_W`=0x1234_5678, `A1_D`=`A2_D`=7 → same cycle `RD1_D`=`RD2_D`=0x1234_5678. After the edge, with `RegWrite_W`=0 → still 0x1234_5678.
- Write to register 0 with `AO_W`=0xDEAD_BEEF, `A1_D`=0 → `RD1_D`=0, `wb_we`=0; register 0 remains 0.
- `Wlevel_Sel_W`=2, `PC_W`=0x0000_3000, `A3_W`=31 → `WD_W`=0x0000_3008. With `PC_W`=0xFFFF_FFFC → `WD_W`=0x0000_0004.
- Drive 10 cycles: 6 with nonzero `Instr_W`, 4 with `Instr_W`=0 → `retire_cnt`=6. Preload the counter near wrap by a long run → 0xFFFF_FFFF rolls over to 0.
